uart_tx_frame: RTL

UART_TX_FRAME -- requirements
Module: uart_tx_frame

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_par_gen.sv | 12 +
 rtl/uart_tx_frame.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parity-mode encodings for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2} state_t;
  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;
endpackage

// File: rtl/uart_par_gen.sv
// uart_par_gen: combinational parity reduction and mode select (even/odd/mark/space).
module uart_par_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            mode,
  output logic                  par
);
  assign par = (mode == PAR_EVEN) ? ^data : (mode == PAR_ODD) ? ~^data : (mode != PAR_SPACE);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART frame serializer, one bit per CLK, with optional parity and 1/2 stop bits.
// Define UART_TX_PAR_INJ_EN to add the PAR_INJ parity-error injection input.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  STOP2,
`ifdef UART_TX_PAR_INJ_EN
  input  logic                  PAR_INJ,
`endif
  output logic                  TX_OUT,
  output logic                  READY,
  output logic                  PAR_BIT,
  output logic                  FRAME_DONE
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH - 1);
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_q, par_d, par_gen, par_en_q, stop2_q, tx_q, tx_d;
  logic                  last, accept, inj_d;
  uart_par_gen #(.DATA_WIDTH(DATA_WIDTH)) u_par (.data(P_DATA), .mode(PAR_MODE), .par(par_gen));
  assign last       = (state == ST_STOP2) || (state == ST_STOP1 && !stop2_q);
  assign READY      = (state == ST_IDLE) || last;
  assign accept     = DATA_VALID && READY;
  assign FRAME_DONE = last;
  assign TX_OUT     = tx_q;
  assign PAR_BIT    = par_q;
  assign data_d     = accept ? P_DATA : data_q;
  assign par_d      = accept ? par_gen : par_q;
`ifdef UART_TX_PAR_INJ_EN
  logic inj_q;
  assign inj_d = accept ? PAR_INJ : inj_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) inj_q <= 1'b0;
    else inj_q <= inj_d;
`else
  assign inj_d = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   state_d = accept ? ST_START : ST_IDLE;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   state_d = (cnt != CNT_MAX) ? ST_DATA : par_en_q ? ST_PARITY : ST_STOP1;
      ST_PARITY: state_d = ST_STOP1;
      ST_STOP1:  state_d = stop2_q ? ST_STOP2 : accept ? ST_START : ST_IDLE;
      ST_STOP2:  state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    cnt_d = (state != ST_DATA) ? cnt : (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    // TX_OUT is registered, so the line value is derived from the state being entered
    tx_d  = (state_d == ST_START) ? 1'b0 :
            (state_d == ST_DATA)   ? data_d[cnt_d] :
            (state_d == ST_PARITY) ? par_d ^ inj_d : 1'b1;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      data_q   <= data_d;
      par_q    <= par_d;
      par_en_q <= accept ? PAR_EN : par_en_q;
      stop2_q  <= accept ? STOP2 : stop2_q;
      tx_q     <= tx_d;
    end
endmodule
